pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller_pkg.sv | 21 ++
 rtl/pipeline_hazard_controller_if.sv | 48 ++++
 rtl/pipeline_hazard_controller_hazard_detect.sv | 29 ++
 rtl/pipeline_hazard_controller.sv | 108 ++++++++++
 tb/tb_pipeline_hazard_controller.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// default SRAM timeout and the register-match helper.
package pipeline_hazard_controller_pkg;

  localparam int unsigned DefaultTimeout = 31;
  localparam int unsigned RegW           = 4;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StWait = 2'd1,
    StErr  = 2'd2
  } state_e;

  // A stage produces a value the ID instruction needs.
  function automatic logic reg_match(input logic            wb_en,
                                     input logic [RegW-1:0] dest,
                                     input logic [RegW-1:0] src);
    return wb_en && (dest == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side signal bundle for the hazard controller. The master is the
// pipeline (drives stage info and requests); the slave is the controller.
interface pipeline_hazard_controller_if
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  logic [RegW-1:0]  src1;
  logic [RegW-1:0]  src2;
  logic             two_src;
  logic             ignore_hazard;
  logic [RegW-1:0]  exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [RegW-1:0]  mem_dest;
  logic             mem_wb_en;
  logic             forward_en;
  logic             branch_taken;
  logic             mem_req;
  logic             sram_ready;
  logic             stat_clear;

  logic             hazard;
  logic             freeze_if;
  logic             freeze_id;
  logic             freeze_exe;
  logic             freeze_mem;
  logic             flush_if_id;
  logic             flush_id_exe;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output src1, src2, two_src, ignore_hazard, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, forward_en, branch_taken, mem_req, sram_ready, stat_clear,
    input  hazard, freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if_id,
           flush_id_exe, timeout_err, stall_count
  );

  modport slave (
    input  src1, src2, two_src, ignore_hazard, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, forward_en, branch_taken, mem_req, sram_ready, stat_clear,
    output hazard, freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if_id,
           flush_id_exe, timeout_err, stall_count
  );

endinterface

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Combinational RAW hazard detection between the ID stage and EXE/MEM.
module pipeline_hazard_controller_hazard_detect
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [RegW-1:0] src1_i,
  input  logic [RegW-1:0] src2_i,
  input  logic            two_src_i,
  input  logic [RegW-1:0] exe_dest_i,
  input  logic            exe_wb_en_i,
  input  logic            exe_mem_read_i,
  input  logic [RegW-1:0] mem_dest_i,
  input  logic            mem_wb_en_i,
  input  logic            forward_en_i,
  output logic            raw_hz_o
);

  logic exe_hit;
  logic mem_hit;

  // With forwarding only a load in EXE still stalls (data not yet available).
  always_comb begin
    exe_hit  = reg_match(exe_wb_en_i, exe_dest_i, src1_i) ||
               (two_src_i && reg_match(exe_wb_en_i, exe_dest_i, src2_i));
    mem_hit  = reg_match(mem_wb_en_i, mem_dest_i, src1_i) ||
               (two_src_i && reg_match(mem_wb_en_i, mem_dest_i, src2_i));
    raw_hz_o = forward_en_i ? (exe_mem_read_i && exe_hit) : (exe_hit || mem_hit);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: RAW stall, branch flush, SRAM wait/timeout FSM
// and a saturating stall-cycle counter.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned CNT_W   = 16
) (
  input logic                          clk,
  input logic                          rst,
  pipeline_hazard_controller_if.slave  bus
);

  localparam int unsigned WaitW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             raw_hz;
  logic             mem_stall;
  logic             hazard;
  logic             freeze_if;

  pipeline_hazard_controller_hazard_detect hazard_detect (
    .src1_i         (bus.src1),
    .src2_i         (bus.src2),
    .two_src_i      (bus.two_src),
    .exe_dest_i     (bus.exe_dest),
    .exe_wb_en_i    (bus.exe_wb_en),
    .exe_mem_read_i (bus.exe_mem_read),
    .mem_dest_i     (bus.mem_dest),
    .mem_wb_en_i    (bus.mem_wb_en),
    .forward_en_i   (bus.forward_en),
    .raw_hz_o       (raw_hz)
  );

  // SRAM wait FSM next state; wait_cnt holds at TIMEOUT in ERR so it never wraps.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (bus.mem_req && !bus.sram_ready) begin
          state_d    = StWait;
          wait_cnt_d = WaitW'(1);
        end
      end
      StWait: begin
        if (bus.sram_ready) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitW'(TIMEOUT)) begin
          state_d = StErr;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StErr: ;
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Stall and flush outputs; everything is forced quiet while reset is held
  // except hazard, which stays a pure function of its inputs.
  always_comb begin
    mem_stall = rst && ((state_q == StErr) || (bus.mem_req && !bus.sram_ready));
    hazard    = raw_hz && !bus.ignore_hazard && !bus.branch_taken && !mem_stall;
    freeze_if = rst && (hazard || mem_stall);

    bus.hazard       = hazard;
    bus.freeze_if    = freeze_if;
    bus.freeze_id    = mem_stall;
    bus.freeze_exe   = mem_stall;
    bus.freeze_mem   = mem_stall;
    // A branch held in frozen EXE flushes in the cycle the stall releases.
    bus.flush_if_id  = rst && bus.branch_taken && !mem_stall;
    bus.flush_id_exe = rst && bus.branch_taken && !mem_stall;
    bus.timeout_err  = (state_q == StErr);
    bus.stall_count  = stall_count_q;
  end

  // Saturating stall counter; clear wins over increment.
  always_comb begin
    stall_count_d = stall_count_q;
    if (bus.stat_clear) begin
      stall_count_d = '0;
    end else if (freeze_if && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // State, wait counter and stall counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_pipeline_hazard_controller;

  localparam int unsigned Timeout = 31;
  localparam int unsigned CntW    = 4;
  localparam int unsigned CntMax  = (1 << CntW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  bit   m_err;
  int   m_waited;
  int   m_count;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.CNT_W(CntW)) bus ();

  pipeline_hazard_controller #(
    .TIMEOUT (Timeout),
    .CNT_W   (CntW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // {hazard, freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if_id, flush_id_exe, timeout_err}
  function automatic logic [7:0] dut_outs();
    return {bus.hazard, bus.freeze_if, bus.freeze_id, bus.freeze_exe, bus.freeze_mem,
            bus.flush_if_id, bus.flush_id_exe, bus.timeout_err};
  endfunction

  // Expected outputs computed straight from the stated equations.
  function automatic logic [7:0] model_outs();
    bit e1, e2, m1, m2, raw, ms, hz, fif, fl;
    e1  = bus.exe_wb_en && (bus.exe_dest == bus.src1);
    e2  = bus.two_src && bus.exe_wb_en && (bus.exe_dest == bus.src2);
    m1  = bus.mem_wb_en && (bus.mem_dest == bus.src1);
    m2  = bus.two_src && bus.mem_wb_en && (bus.mem_dest == bus.src2);
    raw = bus.forward_en ? (bus.exe_mem_read && (e1 || e2)) : (e1 || e2 || m1 || m2);
    ms  = rst && (m_err || (bus.mem_req && !bus.sram_ready));
    hz  = raw && !bus.ignore_hazard && !bus.branch_taken && !ms;
    fif = rst && (hz || ms);
    fl  = rst && bus.branch_taken && !ms;
    return {hz, fif, ms, ms, ms, fl, fl, m_err};
  endfunction

  // Advance the model across one rising edge with the currently driven inputs.
  task automatic model_step();
    logic [7:0] e;
    e = model_outs();
    if (bus.stat_clear) m_count = 0;
    else if (e[6] && m_count < CntMax) m_count++;
    if (!m_err) begin
      if (m_waited == 0) begin
        if (bus.mem_req && !bus.sram_ready) m_waited = 1;
      end else if (bus.sram_ready) begin
        m_waited = 0;
      end else if (m_waited == Timeout) begin
        m_err = 1'b1;
      end else begin
        m_waited++;
      end
    end
  endtask

  task automatic idle_inputs();
    bus.src1 = 4'd0; bus.src2 = 4'd0; bus.two_src = 1'b0; bus.ignore_hazard = 1'b0;
    bus.exe_dest = 4'd0; bus.exe_wb_en = 1'b0; bus.exe_mem_read = 1'b0;
    bus.mem_dest = 4'd0; bus.mem_wb_en = 1'b0; bus.forward_en = 1'b0;
    bus.branch_taken = 1'b0; bus.mem_req = 1'b0; bus.sram_ready = 1'b1;
    bus.stat_clear = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    m_err = 1'b0; m_waited = 0; m_count = 0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    bus.src1 = 4'd3; bus.exe_dest = 4'd3; bus.exe_wb_en = 1'b1;
    bus.mem_req = 1'b1; bus.sram_ready = 1'b0;
    tick(); tick();
    #2;
    checks++;
    if (dut_outs() !== 8'b1000_0000) begin
      errors++; $display("FAIL reset_outs got %b want %b", dut_outs(), 8'b1000_0000);
    end
    checks++;
    if (bus.stall_count !== 4'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", bus.stall_count);
    end
    bus.branch_taken = 1'b1;
    #1;
    checks++;
    if (dut_outs() !== 8'b0000_0000) begin
      errors++; $display("FAIL reset_branch got %b want %b", dut_outs(), 8'b0000_0000);
    end
  endtask

  task automatic test_raw_no_forward();
    do_reset();
    bus.src1 = 4'd3; bus.exe_dest = 4'd3; bus.exe_wb_en = 1'b1;
    #2;
    checks++;
    if (dut_outs() !== 8'b1100_0000) begin
      errors++; $display("FAIL raw_exe got %b want %b", dut_outs(), 8'b1100_0000);
    end
    tick();
    checks++;
    if (bus.stall_count !== 4'd1) begin
      errors++; $display("FAIL raw_exe_count got %0d want 1", bus.stall_count);
    end
    // MEM-stage producer on src2 only counts when two_src is set.
    bus.exe_wb_en = 1'b0; bus.src1 = 4'd1; bus.src2 = 4'd9;
    bus.mem_dest = 4'd9; bus.mem_wb_en = 1'b1;
    #2;
    checks++;
    if (dut_outs() !== 8'b0000_0000) begin
      errors++; $display("FAIL raw_mem_one_src got %b want %b", dut_outs(), 8'b0000_0000);
    end
    bus.two_src = 1'b1;
    #2;
    checks++;
    if (dut_outs() !== 8'b1100_0000) begin
      errors++; $display("FAIL raw_mem_src2 got %b want %b", dut_outs(), 8'b1100_0000);
    end
    bus.ignore_hazard = 1'b1;
    #2;
    checks++;
    if (dut_outs() !== 8'b0000_0000) begin
      errors++; $display("FAIL raw_ignore got %b want %b", dut_outs(), 8'b0000_0000);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.forward_en = 1'b1; bus.src2 = 4'd5; bus.two_src = 1'b1;
    bus.src1 = 4'd0; bus.exe_dest = 4'd5; bus.exe_wb_en = 1'b1;
    #2;
    checks++;
    if (dut_outs() !== 8'b0000_0000) begin
      errors++; $display("FAIL fwd_no_load got %b want %b", dut_outs(), 8'b0000_0000);
    end
    bus.exe_mem_read = 1'b1;
    #2;
    checks++;
    if (dut_outs() !== 8'b1100_0000) begin
      errors++; $display("FAIL fwd_load_use got %b want %b", dut_outs(), 8'b1100_0000);
    end
    // A MEM-stage match is covered by forwarding.
    bus.exe_wb_en = 1'b0; bus.mem_dest = 4'd5; bus.mem_wb_en = 1'b1;
    #2;
    checks++;
    if (dut_outs() !== 8'b0000_0000) begin
      errors++; $display("FAIL fwd_mem_match got %b want %b", dut_outs(), 8'b0000_0000);
    end
  endtask

  task automatic test_branch();
    do_reset();
    bus.src1 = 4'd7; bus.exe_dest = 4'd7; bus.exe_wb_en = 1'b1; bus.branch_taken = 1'b1;
    #2;
    checks++;
    if (dut_outs() !== 8'b0000_0110) begin
      errors++; $display("FAIL branch_flush got %b want %b", dut_outs(), 8'b0000_0110);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    bus.branch_taken = 1'b1; bus.mem_req = 1'b1; bus.sram_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if (dut_outs() !== 8'b0111_1000) begin
        errors++; $display("FAIL wait_cycle%0d got %b want %b", i, dut_outs(), 8'b0111_1000);
      end
      tick();
    end
    bus.sram_ready = 1'b1;
    #2;
    checks++;
    if (dut_outs() !== 8'b0000_0110) begin
      errors++; $display("FAIL wait_release got %b want %b", dut_outs(), 8'b0000_0110);
    end
    tick();
    checks++;
    if (bus.stall_count !== 4'd4) begin
      errors++; $display("FAIL wait_count got %0d want 4", bus.stall_count);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp;
    do_reset();
    bus.mem_req = 1'b1; bus.sram_ready = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      exp = (cyc <= 32) ? 8'b0111_1000 : 8'b0111_1001;
      #2;
      checks++;
      if (dut_outs() !== exp) begin
        errors++; $display("FAIL timeout_cycle%0d got %b want %b", cyc, dut_outs(), exp);
      end
      tick();
    end
    bus.mem_req = 1'b0; bus.sram_ready = 1'b1; bus.branch_taken = 1'b1;
    tick();
    #2;
    checks++;
    if (dut_outs() !== 8'b0111_1001) begin
      errors++; $display("FAIL err_sticky got %b want %b", dut_outs(), 8'b0111_1001);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (dut_outs() !== 8'b0000_0000 || bus.stall_count !== 4'd0) begin
      errors++;
      $display("FAIL err_reset got %b/%0d want %b/0", dut_outs(), bus.stall_count, 8'b0);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic exp;
    do_reset();
    bus.mem_req = 1'b1; bus.sram_ready = 1'b0;
    tick(); tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dut_outs() !== 8'b0000_0000) begin
      errors++; $display("FAIL midwait_reset got %b want %b", dut_outs(), 8'b0000_0000);
    end
    bus.mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    // Idle with SRAM not ready, then a stray ready pulse: neither starts a wait.
    for (int i = 0; i < 6; i++) begin
      bus.sram_ready = (i == 5);
      #2;
      checks++;
      if (dut_outs() !== 8'b0000_0000) begin
        errors++; $display("FAIL midwait_idle%0d got %b want %b", i, dut_outs(), 8'b0);
      end
      tick();
    end
    // A fresh wait must take the full timeout again.
    bus.mem_req = 1'b1; bus.sram_ready = 1'b0;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      exp = (cyc > 32);
      #2;
      checks++;
      if (bus.timeout_err !== exp) begin
        errors++; $display("FAIL rewait_cycle%0d got %b want %b", cyc, bus.timeout_err, exp);
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    do_reset();
    bus.src1 = 4'd2; bus.exe_dest = 4'd2; bus.exe_wb_en = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (bus.stall_count !== 4'd15) begin
      errors++; $display("FAIL sat_count got %0d want 15", bus.stall_count);
    end
    bus.stat_clear = 1'b1;
    #2;
    checks++;
    if (bus.freeze_if !== 1'b1) begin
      errors++; $display("FAIL sat_clear_stall got %b want 1", bus.freeze_if);
    end
    tick();
    checks++;
    if (bus.stall_count !== 4'd0) begin
      errors++; $display("FAIL sat_clear got %0d want 0", bus.stall_count);
    end
    bus.stat_clear = 1'b0;
    tick();
    checks++;
    if (bus.stall_count !== 4'd1) begin
      errors++; $display("FAIL sat_after_clear got %0d want 1", bus.stall_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    int         long_wait;
    do_reset();
    long_wait = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.src1          = 4'($urandom_range(0, 3));
      bus.src2          = 4'($urandom_range(0, 3));
      bus.exe_dest      = 4'($urandom_range(0, 3));
      bus.mem_dest      = 4'($urandom_range(0, 3));
      bus.two_src       = 1'($urandom);
      bus.ignore_hazard = ($urandom_range(0, 7) == 0);
      bus.exe_wb_en     = 1'($urandom);
      bus.exe_mem_read  = 1'($urandom);
      bus.mem_wb_en     = 1'($urandom);
      bus.forward_en    = 1'($urandom);
      bus.branch_taken  = ($urandom_range(0, 5) == 0);
      bus.mem_req       = ($urandom_range(0, 2) == 0);
      bus.sram_ready    = ($urandom_range(0, 3) != 0);
      bus.stat_clear    = ($urandom_range(0, 15) == 0);
      // Late in the run, hold off SRAM long enough to reach the error state.
      if (cyc == 450) long_wait = 40;
      if (long_wait > 0) begin
        bus.mem_req = 1'b1; bus.sram_ready = 1'b0; long_wait--;
      end
      #2;
      exp = model_outs();
      checks++;
      if (dut_outs() !== exp || bus.stall_count !== 4'(m_count)) begin
        errors++;
        $display("FAIL random_cycle%0d got %b/%0d want %b/%0d",
                 cyc, dut_outs(), bus.stall_count, exp, m_count);
      end
      model_step();
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_raw_no_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
